alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer that time-shares a single 32-bit ALU instance between a primary requester (port 0, CPU execute path) and a secondary requester (port 1, e.g. address/debug unit). It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It holds the ALU for multiple cycles on multiply (ctrl 4'b0011) and returns the captured result and zero flag to the originating requester as a one-cycle response pulse.

---
 rtl/alu_share_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one 32-bit ALU between two requesters. Port 0 is the CPU
// execute path and port 1 is a secondary unit. One operation is in flight at
// a time. Multiply (ctrl 4'b0011) holds the ALU for MUL_CYCLES cycles and
// every other code holds it for one cycle. The captured result comes back
// to the issuing port as a one-cycle strobe.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie.
// That build has no round-robin history register, so port 1 can starve.
// Without the macro, ties are broken round-robin.

module alu_share_arbiter #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic [4:0]  req0_shamt_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_ctrl_i,
  input  logic [4:0]  req1_shamt_i,

  output logic        rsp0_valid_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,

  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [4:0]  alu_shamt_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [3:0] CTRL_MUL  = 4'b0011;
  // 4'b1111 is a code the ALU maps to 0, so the reset operand is harmless
  localparam logic [3:0] CTRL_IDLE = 4'b1111;
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_capture;

  logic        r_owner;
  logic [31:0] r_op_src1;
  logic [31:0] r_op_src2;
  logic [3:0]  r_op_ctrl;
  logic [4:0]  r_op_shamt;

  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;

  logic        w_window;
  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_hs;

  logic [31:0] w_sel_src1;
  logic [31:0] w_sel_src2;
  logic [3:0]  w_sel_ctrl;
  logic [4:0]  w_sel_shamt;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic        r_last_grant;
`endif

  // Grant and ready: accept window is IDLE or RESP, never while reset is high
  always_comb begin
    w_window = 1'b0;
    w_grant1 = 1'b0;
    if (!rst_i && (r_state == ST_IDLE || r_state == ST_RESP)) begin
      w_window = 1'b1;
    end else begin
      w_window = 1'b0;
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    w_grant1 = req1_valid_i && !req0_valid_i;
`else
    if (req0_valid_i && req1_valid_i) begin
      w_grant1 = !r_last_grant;
    end else begin
      w_grant1 = req1_valid_i;
    end
`endif
    w_ready0 = w_window && req0_valid_i && !w_grant1;
    w_ready1 = w_window && req1_valid_i && w_grant1;
    w_hs     = w_ready0 || w_ready1;
  end

  assign req0_ready_o = w_ready0;
  assign req1_ready_o = w_ready1;

  // Operand mux: select the fields of the granted port
  always_comb begin
    w_sel_src1  = req0_src1_i;
    w_sel_src2  = req0_src2_i;
    w_sel_ctrl  = req0_ctrl_i;
    w_sel_shamt = req0_shamt_i;
    if (w_grant1) begin
      w_sel_src1  = req1_src1_i;
      w_sel_src2  = req1_src2_i;
      w_sel_ctrl  = req1_ctrl_i;
      w_sel_shamt = req1_shamt_i;
    end else begin
      w_sel_src1  = req0_src1_i;
      w_sel_src2  = req0_src2_i;
      w_sel_ctrl  = req0_ctrl_i;
      w_sel_shamt = req0_shamt_i;
    end
  end

  // Next state, hold counter and result capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_hs) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_hs) begin
      w_cnt_nxt = (w_sel_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  // State register and hold counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand register and owner: loaded on a handshake, held otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner    <= 1'b0;
      r_op_src1  <= 32'd0;
      r_op_src2  <= 32'd0;
      r_op_ctrl  <= CTRL_IDLE;
      r_op_shamt <= 5'd0;
    end else if (w_hs) begin
      r_owner    <= w_grant1;
      r_op_src1  <= w_sel_src1;
      r_op_src2  <= w_sel_src2;
      r_op_ctrl  <= w_sel_ctrl;
      r_op_shamt <= w_sel_shamt;
    end else begin
      r_owner    <= r_owner;
      r_op_src1  <= r_op_src1;
      r_op_src2  <= r_op_src2;
      r_op_ctrl  <= r_op_ctrl;
      r_op_shamt <= r_op_shamt;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin history: the port that won the latest handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_last_grant <= w_grant1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  // Response register: captures the ALU on the final EXEC cycle and holds it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result <= alu_result_i;
      r_rsp_zero   <= alu_zero_i;
    end else begin
      r_rsp_result <= r_rsp_result;
      r_rsp_zero   <= r_rsp_zero;
    end
  end

  // The strobe is suppressed during reset, so an aborted op never reports back
  assign rsp0_valid_o = !rst_i && (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid_o = !rst_i && (r_state == ST_RESP) &&  r_owner;
  assign rsp_result_o = r_rsp_result;
  assign rsp_zero_o   = r_rsp_zero;

  assign alu_src1_o  = r_op_src1;
  assign alu_src2_o  = r_op_src2;
  assign alu_ctrl_o  = r_op_ctrl;
  assign alu_shamt_o = r_op_shamt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of accept windows, latencies and results.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int MUL = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        p_valid [2];
  logic [31:0] p_src1  [2];
  logic [31:0] p_src2  [2];
  logic [3:0]  p_ctrl  [2];
  logic [4:0]  p_shamt [2];

  logic        req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_zero_o;
  logic [31:0] rsp_result_o, alu_src1_o, alu_src2_o, alu_result;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  alu_shamt_o;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Reference ALU behaviour, also used to drive the DUT's ALU port
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c, input logic [4:0] s);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a * b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return b << s;
      4'b1001: return b >> s;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o);
  assign alu_zero   = (alu_result == 32'd0);

  alu_share_arbiter #(.MUL_CYCLES(MUL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(p_valid[0]), .req0_ready_o(req0_ready_o),
    .req0_src1_i(p_src1[0]), .req0_src2_i(p_src2[0]),
    .req0_ctrl_i(p_ctrl[0]), .req0_shamt_i(p_shamt[0]),
    .req1_valid_i(p_valid[1]), .req1_ready_o(req1_ready_o),
    .req1_src1_i(p_src1[1]), .req1_src2_i(p_src2[1]),
    .req1_ctrl_i(p_ctrl[1]), .req1_shamt_i(p_shamt[1]),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_shamt_o(alu_shamt_o),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The ALU is free from cycle m_next on; an op accepted at T with latency L
  // reports at T+L and the ALU is free again at T+L.
  int          m_next = 0;
  int          m_rsp_cyc = -1;
  logic        m_rsp_port = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic        m_pend_z = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_z = 1'b0;
  logic        m_last = 1'b1;
  logic [31:0] m_a1 = 32'd0, m_a2 = 32'd0;
  logic [3:0]  m_ac = 4'b1111;
  logic [4:0]  m_as = 5'd0;

  always @(negedge clk) begin : model
    logic win, g1, e0, e1, p;
    if (rst_i) begin
      chk("rst_ready0", req0_ready_o, 32'd0);
      chk("rst_ready1", req1_ready_o, 32'd0);
      chk("rst_rsp0", rsp0_valid_o, 32'd0);
      chk("rst_rsp1", rsp1_valid_o, 32'd0);
      m_next = cyc + 1; m_rsp_cyc = -1; m_res = 32'd0; m_z = 1'b0;
      m_last = 1'b1; m_a1 = 32'd0; m_a2 = 32'd0; m_ac = 4'b1111; m_as = 5'd0;
    end else begin
      win = (cyc >= m_next);
      if (p_valid[0] && p_valid[1]) g1 = FIXED ? 1'b0 : !m_last;
      else g1 = p_valid[1];
      e0 = win && p_valid[0] && !g1;
      e1 = win && p_valid[1] && g1;
      if (cyc == m_rsp_cyc) begin
        m_res = m_pend; m_z = m_pend_z;
      end
      chk("m_ready0", req0_ready_o, {31'd0, e0});
      chk("m_ready1", req1_ready_o, {31'd0, e1});
      chk("m_rsp0", rsp0_valid_o, {31'd0, (cyc == m_rsp_cyc) && !m_rsp_port});
      chk("m_rsp1", rsp1_valid_o, {31'd0, (cyc == m_rsp_cyc) && m_rsp_port});
      chk("m_result", rsp_result_o, m_res);
      chk("m_zero", rsp_zero_o, {31'd0, m_z});
      chk("m_alu_src1", alu_src1_o, m_a1);
      chk("m_alu_src2", alu_src2_o, m_a2);
      chk("m_alu_ctrl", alu_ctrl_o, {28'd0, m_ac});
      chk("m_alu_shamt", alu_shamt_o, {27'd0, m_as});
      if (e0 || e1) begin
        p = e1;
        m_a1 = p_src1[p]; m_a2 = p_src2[p]; m_ac = p_ctrl[p]; m_as = p_shamt[p];
        m_pend = alu_f(m_a1, m_a2, m_ac, m_as);
        m_pend_z = (m_pend == 32'd0);
        m_rsp_port = p;
        m_rsp_cyc = cyc + ((m_ac == 4'b0011) ? (1 + MUL) : 2);
        m_next = m_rsp_cyc;
        m_last = p;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [4:0] s);
    p_valid[p] = 1'b1; p_src1[p] = a; p_src2[p] = b; p_ctrl[p] = c; p_shamt[p] = s;
  endtask

  logic [3:0] ctrl_tab [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                                4'b0111, 4'b1000, 4'b1001, 4'b1100, 4'b0100};

  task automatic rand_req(input int p);
    logic [31:0] a, b;
    int r;
    a = $urandom;
    r = $urandom_range(0, 3);
    if (r == 0) b = a;
    else if (r == 1) begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
    else b = $urandom;
    set_req(p, a, b, ctrl_tab[$urandom_range(0, 9)], 5'($urandom_range(0, 31)));
  endtask

  initial begin : stim
    logic prev, eg1;
    logic hs [2];
    for (int p = 0; p < 2; p++) begin
      p_valid[p] = 1'b0; p_src1[p] = 32'd0; p_src2[p] = 32'd0;
      p_ctrl[p] = 4'd0; p_shamt[p] = 5'd0;
    end
    rst_i = 1'b1;
    step();                                     // cycle 1, still in reset
    set_req(0, 32'd5, 32'd7, 4'b0010, 5'd0);
    @(negedge clk);
    chk("reset_valid_no_ready0", req0_ready_o, 32'd0);
    chk("reset_alu_ctrl", alu_ctrl_o, 32'hF);
    chk("reset_result", rsp_result_o, 32'd0);
    chk("reset_alu_src1", alu_src1_o, 32'd0);
    step(); rst_i = 1'b0;                       // T: add accepted
    @(negedge clk);
    chk("add_ready0", req0_ready_o, 32'd1);
    chk("add_ready1", req1_ready_o, 32'd0);
    step(); p_valid[0] = 1'b0;                  // T+1
    @(negedge clk);
    chk("add_no_early_rsp", rsp0_valid_o, 32'd0);
    step();                                     // T+2
    @(negedge clk);
    chk("add_rsp0", rsp0_valid_o, 32'd1);
    chk("add_rsp1", rsp1_valid_o, 32'd0);
    chk("add_result", rsp_result_o, 32'd12);
    chk("add_zero", rsp_zero_o, 32'd0);

    // multiply on port 1, then subtract-to-zero queued on port 0
    step(); set_req(1, 32'hFFFFFFFD, 32'd4, 4'b0011, 5'd0);
    @(negedge clk);
    chk("mul_ready1", req1_ready_o, 32'd1);
    step(); p_valid[1] = 1'b0; set_req(0, 32'd9, 32'd9, 4'b0110, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("mul_busy_ready0", req0_ready_o, 32'd0);
      chk("mul_busy_ready1", req1_ready_o, 32'd0);
      chk("mul_busy_rsp1", rsp1_valid_o, 32'd0);
      step();
    end
    @(negedge clk);                             // T+4
    chk("mul_rsp1", rsp1_valid_o, 32'd1);
    chk("mul_rsp0", rsp0_valid_o, 32'd0);
    chk("mul_result", rsp_result_o, 32'hFFFFFFF4);
    chk("sub_ready0_in_resp", req0_ready_o, 32'd1);
    step(); p_valid[0] = 1'b0;
    @(negedge clk);
    chk("sub_no_early_rsp", rsp0_valid_o, 32'd0);
    step();
    @(negedge clk);
    chk("sub_rsp0", rsp0_valid_o, 32'd1);
    chk("sub_result", rsp_result_o, 32'd0);
    chk("sub_zero", rsp_zero_o, 32'd1);

    // tie: both ports valid continuously after a fresh reset
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    set_req(0, 32'd10, 32'd20, 4'b0010, 5'd0);
    set_req(1, 32'd1000, 32'd2000, 4'b0010, 5'd0);
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      eg1 = FIXED ? 1'b0 : ((k % 2) == 1);
      chk("tie_ready0", req0_ready_o, {31'd0, !eg1});
      chk("tie_ready1", req1_ready_o, {31'd0, eg1});
      if (k > 0) begin
        chk("tie_rsp0", rsp0_valid_o, {31'd0, !prev});
        chk("tie_rsp1", rsp1_valid_o, {31'd0, prev});
        chk("tie_result", rsp_result_o, prev ? 32'd3000 : 32'd30);
      end
      prev = eg1;
      step();
      if (k == 3) begin p_valid[0] = 1'b0; p_valid[1] = 1'b0; end
      @(negedge clk);
      chk("tie_gap_ready0", req0_ready_o, 32'd0);
      chk("tie_gap_ready1", req1_ready_o, 32'd0);
      step();
    end
    @(negedge clk);
    chk("tie_last_rsp1", rsp1_valid_o, {31'd0, prev});
    chk("tie_last_result", rsp_result_o, prev ? 32'd3000 : 32'd30);

    // reset in the middle of a multiply
    step(); set_req(0, 32'd6, 32'd7, 4'b0011, 5'd0);
    @(negedge clk);
    chk("rm_ready0", req0_ready_o, 32'd1);
    step(); p_valid[0] = 1'b0;
    @(negedge clk);
    step(); rst_i = 1'b1;                       // T+2
    @(negedge clk);
    chk("rm_rsp0_in_rst", rsp0_valid_o, 32'd0);
    step(); rst_i = 1'b0; set_req(1, 32'd3, 32'd4, 4'b0010, 5'd0);
    @(negedge clk);                             // T+3
    chk("rm_ready1_after", req1_ready_o, 32'd1);
    chk("rm_alu_ctrl_reset", alu_ctrl_o, 32'hF);
    chk("rm_result_reset", rsp_result_o, 32'd0);
    step(); p_valid[1] = 1'b0;
    @(negedge clk);
    chk("rm_no_rsp0", rsp0_valid_o, 32'd0);
    step();
    @(negedge clk);
    chk("rm_rsp1", rsp1_valid_o, 32'd1);
    chk("rm_rsp0", rsp0_valid_o, 32'd0);
    chk("rm_result", rsp_result_o, 32'd7);
    step();

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hs[0] = p_valid[0] && req0_ready_o;
      hs[1] = p_valid[1] && req1_ready_o;
      step();
      rst_i = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++) begin
        if (hs[p] || !p_valid[p]) begin
          if ($urandom_range(0, 99) < 55) rand_req(p);
          else p_valid[p] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          p_valid[p] = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
